// File: rtl/input_conditioner_pkg.sv
// Shared defaults for the input conditioner and its debounce channels.
// Parameter defaults live here so the top and sub-module agree without repetition.
package input_conditioner_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int HOLD_CYCLES_DEF     = 100;
    localparam int CNT_W_DEF           = 8;
    localparam int PRESS_CNT_W         = 8;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One-bit synchronizer chain followed by a debounce counter.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from a clean raw change to stable; no backpressure.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_nxt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable     = stable_q;
    // Lets the parent register edge pulses in the same cycle the stable level flips.
    assign stable_nxt = stable_d;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces sw1/sw2/button; derives press/release pulses, long-press flag, press counter.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges raw->level, pulses aligned with the level edge; no backpressure.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sw1_raw,
    input  logic                   sw2_raw,
    input  logic                   button_raw,
    output logic                   sw1,
    output logic                   sw2,
    output logic                   button,
    output logic                   btn_press,
    output logic                   btn_release,
    output logic                   btn_held,
    output logic [PRESS_CNT_W-1:0] press_count
);

    logic [1:0] sw_nxt_unused;
    logic       btn_stable, btn_nxt;

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_sw1 (.clk(clk), .reset(reset), .raw(sw1_raw), .stable(sw1), .stable_nxt(sw_nxt_unused[0]));

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_sw2 (.clk(clk), .reset(reset), .raw(sw2_raw), .stable(sw2), .stable_nxt(sw_nxt_unused[1]));

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_btn (.clk(clk), .reset(reset), .raw(button_raw), .stable(btn_stable), .stable_nxt(btn_nxt));

    logic                   btn_press_q, btn_press_d;
    logic                   btn_release_q, btn_release_d;
    logic                   btn_held_q, btn_held_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

    always_comb begin
        btn_press_d   = btn_nxt & ~btn_stable;
        btn_release_d = ~btn_nxt & btn_stable;

        // Counting starts the cycle after the level rises and clears on the release edge.
        hold_cnt_d = '0;
        if (btn_nxt && btn_stable) begin
            if (hold_cnt_q != CNT_W'(HOLD_CYCLES)) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end
        btn_held_d = btn_nxt && (hold_cnt_d == CNT_W'(HOLD_CYCLES));

        press_count_d = press_count_q;
        if (btn_press_d) begin
            press_count_d = press_count_q + PRESS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
            btn_held_q    <= 1'b0;
            hold_cnt_q    <= '0;
            press_count_q <= '0;
        end else begin
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
            btn_held_q    <= btn_held_d;
            hold_cnt_q    <= hold_cnt_d;
            press_count_q <= press_count_d;
        end
    end

    assign button      = btn_stable;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;
    assign btn_held    = btn_held_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed stimulus pushes expected output events (cycle, kind, value) into a queue;
// a negedge monitor detects output events on the DUT and pops/compares them.
module tb_input_conditioner;

    localparam int LAT  = 6;
    localparam int HOLD = 20;

    // Event kinds: 0 sw1, 1 sw2, 2 button, 3 btn_press, 4 btn_release, 5 btn_held
    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sw1_raw = 1'b1;
    logic       sw2_raw = 1'b1;
    logic       button_raw = 1'b1;
    logic       sw1, sw2, button, btn_press, btn_release, btn_held;
    logic [7:0] press_count;

    input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .sw1_raw(sw1_raw), .sw2_raw(sw2_raw), .button_raw(button_raw),
        .sw1(sw1), .sw2(sw2), .button(button),
        .btn_press(btn_press), .btn_release(btn_release), .btn_held(btn_held),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         presses_seen = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic expect_ev(input int c, input int k, input int v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic [5:0] prev = 6'd0;
    logic [5:0] cur;
    ev_t        m_e;
    int         m_val;
    bit         m_hap;

    always @(negedge clk) begin
        cur = {btn_held, btn_release, btn_press, button, sw2, sw1};
        if (!reset) begin
            checks++;
            if (cur != 6'd0 || press_count != 8'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d outputs=%b press_count=%0d required all zero",
                         cyc, cur, press_count);
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                m_e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_event kind=%0d not seen by cycle %0d, required at cycle %0d",
                         m_e.kind, cyc, m_e.cyc);
            end
            for (int k = 0; k < 6; k++) begin
                m_hap = (k == 3 || k == 4) ? cur[k] : (cur[k] != prev[k]);
                if (m_hap) begin
                    if (k == 3) presses_seen++;
                    m_val = (k == 3 || k == 4) ? int'(press_count) : int'(cur[k]);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event kind=%0d val=%0d at cycle %0d, required no event",
                                 k, m_val, cyc);
                    end else begin
                        m_e = exp_q.pop_front();
                        if (m_e.kind != k || m_e.cyc != cyc || m_e.val != m_val) begin
                            failures++;
                            $display("FAIL event got kind=%0d cyc=%0d val=%0d, required kind=%0d cyc=%0d val=%0d",
                                     k, cyc, m_val, m_e.kind, m_e.cyc, m_e.val);
                        end
                    end
                end
            end
        end
        prev = cur;
    end

    // Stimulus
    int c, d, r, ps0;

    initial begin
        // Reset 100 ns with every raw input high; all three levels rise after full latency.
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        c = cyc;
        exp_cnt = exp_cnt + 8'd1;
        expect_ev(c + LAT, 0, 1);
        expect_ev(c + LAT, 1, 1);
        expect_ev(c + LAT, 2, 1);
        expect_ev(c + LAT, 3, int'(exp_cnt));
        repeat (10) @(negedge clk);
        c = cyc;
        sw1_raw = 1'b0;
        sw2_raw = 1'b0;
        button_raw = 1'b0;
        expect_ev(c + LAT, 0, 0);
        expect_ev(c + LAT, 1, 0);
        expect_ev(c + LAT, 2, 0);
        expect_ev(c + LAT, 4, int'(exp_cnt));
        repeat (10) @(negedge clk);

        // Clean switch rise, no button pulses.
        @(negedge clk);
        c = cyc;
        sw1_raw = 1'b1;
        expect_ev(c + LAT, 0, 1);
        repeat (10) @(negedge clk);

        // Bouncy button: toggles every 15 ns, final rise at c*10+92 ns -> settles before edge c+10.
        @(negedge clk);
        c = cyc;
        #2;
        for (int i = 0; i < 7; i++) begin
            button_raw = ~button_raw;
            if (i < 6) #15;
        end
        exp_cnt = exp_cnt + 8'd1;
        expect_ev(c + 15, 2, 1);
        expect_ev(c + 15, 3, int'(exp_cnt));

        // Long hold, then release: held rises 20 cycles after button, falls with release.
        expect_ev(c + 15 + HOLD, 5, 1);
        repeat (30) @(negedge clk);
        d = cyc;
        button_raw = 1'b0;
        expect_ev(d + LAT, 2, 0);
        expect_ev(d + LAT, 4, int'(exp_cnt));
        expect_ev(d + LAT, 5, 0);
        repeat (10) @(negedge clk);

        // Counter wrap after 256 clean presses from zero.
        @(negedge clk);
        #2;
        sw1_raw = 1'b0;
        reset = 1'b0;
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        ps0 = presses_seen;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            c = cyc;
            button_raw = 1'b1;
            exp_cnt = exp_cnt + 8'd1;
            expect_ev(c + LAT, 2, 1);
            expect_ev(c + LAT, 3, int'(exp_cnt));
            repeat (8) @(negedge clk);
            c = cyc;
            button_raw = 1'b0;
            expect_ev(c + LAT, 2, 0);
            expect_ev(c + LAT, 4, int'(exp_cnt));
            repeat (8) @(negedge clk);
        end
        #1;
        checks++;
        if (presses_seen - ps0 != 256) begin
            failures++;
            $display("FAIL press_pulse_total got %0d required 256", presses_seen - ps0);
        end
        checks++;
        if (press_count != 8'h00) begin
            failures++;
            $display("FAIL press_count_wrap got 0x%02h required 0x00", press_count);
        end

        // Reset mid-debounce (cnt=3) with sw2 already high: outputs clear at once.
        @(negedge clk);
        c = cyc;
        sw2_raw = 1'b1;
        expect_ev(c + LAT, 1, 1);
        repeat (8) @(negedge clk);
        @(negedge clk);
        button_raw = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sw1, sw2, button, btn_press, btn_release, btn_held} != 6'd0 || press_count != 8'd0) begin
            failures++;
            $display("FAIL reset_immediate got sw2=%b button=%b held=%b count=%0d required all zero",
                     sw2, button, btn_held, press_count);
        end
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        r = cyc;
        exp_cnt = exp_cnt + 8'd1;
        expect_ev(r + LAT, 1, 1);
        expect_ev(r + LAT, 2, 1);
        expect_ev(r + LAT, 3, int'(exp_cnt));
        expect_ev(r + LAT + HOLD, 5, 1);
        repeat (30) @(negedge clk);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end conditioning stage that sits directly upstream of the lab state machine. It takes raw asynchronous board inputs (sw1, sw2, button) and produces synchronized, debounced levels. It also produces single-cycle press/release pulses, a long-press flag and a wrapping press counter. The state machine consumes only these clean signals and never sees raw pins.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each synchronizer chain (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its stable value before the stable value flips (minimum 2)
HOLD_CYCLES, 100, cycles the debounced button must stay high before btn_held asserts (must be greater than DEBOUNCE_CYCLES)
CNT_W, 8, width of the debounce and hold counters (must hold HOLD_CYCLES)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
sw1_raw  input  1  raw switch 1 pin, asynchronous
sw2_raw  input  1  raw switch 2 pin, asynchronous
button_raw  input  1  raw push-button pin, asynchronous, bouncy
sw1  output  1  debounced switch 1 level
sw2  output  1  debounced switch 2 level
button  output  1  debounced button level
btn_press  output  1  one-cycle pulse on debounced button 0->1
btn_release  output  1  one-cycle pulse on debounced button 1->0
btn_held  output  1  high while the debounced button has been high at least HOLD_CYCLES cycles
press_count  output  8  number of btn_press pulses, wraps 255->0

Behaviour:
- Reset (reset=0) is asynchronous and clears immediately: all synchronizer flops, counters and outputs go to 0. Every output resets to 0.
- Synchronizer: each raw input passes through its own SYNC_STAGES-flop chain. Call the last flop "s".
- Debounce, applied per channel:
  - If s equals the stable value, cnt is set to 0.
  - Else, if cnt equals DEBOUNCE_CYCLES-1, stable is set to s and cnt to 0.
  - Else, cnt increments by 1.
- Latency: a clean raw transition that settles before edge 1 appears on the stable output after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is 18 cycles.
- A bounce shorter than DEBOUNCE_CYCLES cycles at s resets cnt and never changes the stable output.
- btn_press and btn_release are registered. Each is high for exactly the one cycle in which the debounced button first shows the new value, aligned with that edge. They are never high together.
- Hold logic:
  - While the debounced button is 0, hold_cnt=0 and btn_held=0.
  - While it is 1, hold_cnt increments and saturates at HOLD_CYCLES.
  - btn_held goes to 1 on the edge where hold_cnt reaches HOLD_CYCLES.
  - btn_held goes to 0 in the same cycle btn_release pulses.
- press_count increments by 1 on each btn_press. It wraps modulo 256 with no saturation.
- Reset mid-debounce: partial count is lost. Reset mid-hold: btn_held drops immediately.
- After reset release with an input already high:
  - The output rises after the full latency.
  - For button, this rise produces a btn_press and increments press_count.
- Reset is not synchronized internally. Reset deassertion timing is the integrator's responsibility.
- Stable switch outputs produce no pulses.

Decomposition:
- Shared package holds: default constants (SYNC_STAGES, DEBOUNCE_CYCLES, HOLD_CYCLES, CNT_W) and the press_count width constant (8).
- One sub-module, debounce_channel (synchronizer plus debounce counter, one bit, parameterised), is instantiated three times.
- Edge, hold and count logic stay in the top.

Test Plan:
Bench overrides DEBOUNCE_CYCLES=4 and HOLD_CYCLES=20, clock period 10 ns, so latency is 6 cycles.
- Reset held low for 100 ns with all raw inputs at 1 -> every output 0 during reset. After release, sw1, sw2 and button rise at edge 6, btn_press pulses once, press_count=1.
- sw1_raw 0->1 clean -> sw1 rises exactly 6 edges later. No pulse on btn_press or btn_release.
- button_raw toggled 1/0 every 15 ns for 100 ns, then held 1 -> button rises once 6 edges after the final settle, exactly one btn_press, press_count +1.
- button_raw held high 300 ns, then low -> btn_held rises 20 cycles after button. btn_held and button fall together on btn_release. Release occurs 6 edges after the raw fall.
- 256 clean presses from press_count=0 -> press_count returns to 0x00 and btn_press count is 256.
- reset driven low at debounce cnt=3 while button_raw=1 -> outputs 0 immediately. After release, button rises only after the full 6 edges.
